// File: rtl/ahb_pkg.sv
// Shared AHB bus types (encodings match the FreeAHB manager) and the byte-lane helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } t_htrans;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HWORD = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_W128  = 3'd4,
        HSIZE_W256  = 3'd5,
        HSIZE_W512  = 3'd6,
        HSIZE_W1024 = 3'd7
    } t_hsize;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } t_hburst;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } t_hresp;

    localparam int unsigned MAX_BE_W = 128;

    // Byte-enable mask for a transfer of 'size' starting at byte lane 'offset'; callers truncate.
    function automatic logic [MAX_BE_W-1:0] be_mask(input logic [6:0] offset, input t_hsize size);
        logic [MAX_BE_W-1:0] ones;
        ones = (MAX_BE_W'(1) << (8'd1 << size)) - MAX_BE_W'(1);
        return ones << offset;
    endfunction

endpackage

// File: rtl/ahb_sub_wait_ctr.sv
// Loadable 4-bit down-counter with a done flag; sequences subordinate wait states.
module ahb_sub_wait_ctr (
    input  logic       i_hclk,
    input  logic       i_hreset_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done_c
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate fronting a single-port synchronous SRAM, with wait states,
// two-cycle ERROR for illegal accesses and two-cycle RETRY on request.
module ahb_subordinate_sram
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WDT    = 32,
    parameter int unsigned ADDR_WDT    = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                                   i_hclk,
    input  logic                                   i_hreset_n,
    input  logic                                   i_hsel,
    input  logic [31:0]                            i_haddr,
    input  t_htrans                                i_htrans,
    input  logic                                   i_hwrite,
    input  t_hsize                                 i_hsize,
    input  t_hburst                                i_hburst,
    input  logic [DATA_WDT-1:0]                    i_hwdata,
    input  logic                                   i_hready,
    output logic                                   o_hreadyout,
    output t_hresp                                 o_hresp,
    output logic [DATA_WDT-1:0]                    o_hrdata,
    input  logic                                   i_retry_req,
    output logic                                   o_mem_en,
    output logic                                   o_mem_we,
    output logic [ADDR_WDT-$clog2(DATA_WDT/8)-1:0] o_mem_addr,
    output logic [DATA_WDT/8-1:0]                  o_mem_be,
    output logic [DATA_WDT-1:0]                    o_mem_wdata,
    input  logic [DATA_WDT-1:0]                    i_mem_rdata
);

    localparam int unsigned BE_W      = DATA_WDT / 8;
    localparam int unsigned LANE_W    = $clog2(BE_W);
    localparam int unsigned MEM_AW    = ADDR_WDT - LANE_W;
    localparam bit          HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RDLAT, S_ERR1, S_ERR2, S_RTY1, S_RTY2
    } t_state;

    t_state              r_state, w_state_nxt;
    logic                r_hwrite;
    logic [MEM_AW-1:0]   r_waddr;
    logic [BE_W-1:0]     r_be;
    logic                r_retry;
    logic                r_rd_cmpl, w_rd_cmpl_nxt;
    logic                w_wr_pend_nxt;
    logic [DATA_WDT-1:0] r_hrdata;
    logic                w_hreadyout_nxt, w_mem_en_nxt, w_mem_we_nxt;
    t_hresp              w_hresp_nxt;
    logic                w_ctr_load, w_ctr_dec, w_ctr_done;
    logic                w_rty_take;
    logic                w_accept, w_illegal, w_final, w_capture;
    logic                w_unused_hburst;

    assign w_accept  = i_hsel & i_hready & ((i_htrans == HTRANS_NONSEQ) | (i_htrans == HTRANS_SEQ));
    assign w_illegal = ((i_haddr >> ADDR_WDT) != 32'd0)
                     | ((32'd8 << i_hsize) > DATA_WDT)
                     | ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0);
    // Cycles in which this subordinate drives HREADYOUT high end a data phase.
    assign w_final   = (r_state == S_IDLE) | (r_state == S_ERR2) | (r_state == S_RTY2);
    assign w_capture = w_final & w_accept;
    assign w_ctr_dec = (r_state == S_WAIT);
    assign w_unused_hburst = ^i_hburst;

    ahb_sub_wait_ctr u_wait_ctr (
        .i_hclk     (i_hclk),
        .i_hreset_n (i_hreset_n),
        .i_load     (w_ctr_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_ctr_dec),
        .o_done_c   (w_ctr_done)
    );

    // State register together with the registered bus and SRAM strobes.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_state     <= S_IDLE;
            r_rd_cmpl   <= 1'b0;
            o_hreadyout <= 1'b1;
            o_hresp     <= HRESP_OKAY;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_cmpl   <= w_rd_cmpl_nxt;
            o_hreadyout <= w_hreadyout_nxt;
            o_hresp     <= w_hresp_nxt;
            o_mem_en    <= w_mem_en_nxt;
            o_mem_we    <= w_mem_we_nxt;
        end
    end

    // Next state; every final cycle re-evaluates accept so transfers pipeline without bubbles.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_pend_nxt = 1'b0;
        w_rd_cmpl_nxt = 1'b0;
        w_ctr_load    = 1'b0;
        w_rty_take    = 1'b0;
        case (r_state)
            S_IDLE, S_ERR2, S_RTY2: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    if (r_retry) begin
                        w_state_nxt = S_RTY1;
                        w_rty_take  = 1'b1;
                    end else if (w_illegal) begin
                        w_state_nxt = S_ERR1;
                    end else if (HAS_WAIT) begin
                        w_state_nxt = S_WAIT;
                        w_ctr_load  = 1'b1;
                    end else if (i_hwrite) begin
                        w_wr_pend_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RDLAT;
                    end
                end
            end
            S_WAIT: begin
                if (w_ctr_done) begin
                    if (r_hwrite) begin
                        w_state_nxt   = S_IDLE;
                        w_wr_pend_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RDLAT;
                    end
                end
            end
            S_RDLAT: begin
                w_state_nxt   = S_IDLE;
                w_rd_cmpl_nxt = 1'b1;
            end
            S_ERR1:  w_state_nxt = S_ERR2;
            S_RTY1:  w_state_nxt = S_RTY2;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        w_hreadyout_nxt = 1'b1;
        w_hresp_nxt     = HRESP_OKAY;
        case (w_state_nxt)
            S_WAIT, S_RDLAT: w_hreadyout_nxt = 1'b0;
            S_ERR1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = HRESP_ERROR;
            end
            S_ERR2:  w_hresp_nxt = HRESP_ERROR;
            S_RTY1: begin
                w_hreadyout_nxt = 1'b0;
                w_hresp_nxt     = HRESP_RETRY;
            end
            S_RTY2:  w_hresp_nxt = HRESP_RETRY;
            default: ;
        endcase
        w_mem_en_nxt = (w_state_nxt == S_RDLAT) | w_wr_pend_nxt;
        w_mem_we_nxt = w_wr_pend_nxt;
    end

    // Address-phase capture.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_hwrite <= 1'b0;
            r_waddr  <= '0;
            r_be     <= '0;
        end else if (w_capture) begin
            r_hwrite <= i_hwrite;
            r_waddr  <= i_haddr[ADDR_WDT-1:LANE_W];
            r_be     <= BE_W'(be_mask(7'(i_haddr[LANE_W-1:0]), i_hsize));
        end
    end

    // Sticky retry request; a request arriving as the flag is consumed is kept.
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_retry <= 1'b0;
        end else begin
            r_retry <= i_retry_req | (r_retry & ~w_rty_take);
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_hrdata <= '0;
        end else if (r_rd_cmpl) begin
            r_hrdata <= i_mem_rdata;
        end
    end

    // SRAM data arrives one cycle after the strobe, so the completion cycle forwards it directly.
    assign o_hrdata    = r_rd_cmpl ? i_mem_rdata : r_hrdata;
    assign o_mem_addr  = r_waddr;
    assign o_mem_be    = r_be;
    assign o_mem_wdata = i_hwdata;

endmodule

// File: tb/tb_ahb_subordinate_sram.sv
// Scoreboard bench: two subordinates (0 and 3 wait states) behind a small HREADY mux.
module tb_ahb_subordinate_sram;
    import ahb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        sel;
    logic [31:0] haddr, hwdata;
    t_htrans     htrans;
    logic        hwrite;
    t_hsize      hsize;
    t_hburst     hburst;
    logic        retry0, retry1;
    logic        hready_g, owner;

    logic        hrdy0, hrdy1, men0, men1, mwe0, mwe1;
    t_hresp      resp0, resp1;
    logic [31:0] rdata0, rdata1, mwd0, mwd1, mrd0, mrd1;
    logic [13:0] maddr0, maddr1;
    logic [3:0]  mbe0, mbe1;

    ahb_subordinate_sram #(.DATA_WDT(32), .ADDR_WDT(16), .WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel == 1'b0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hready_g), .o_hreadyout(hrdy0), .o_hresp(resp0),
        .o_hrdata(rdata0), .i_retry_req(retry0), .o_mem_en(men0), .o_mem_we(mwe0),
        .o_mem_addr(maddr0), .o_mem_be(mbe0), .o_mem_wdata(mwd0), .i_mem_rdata(mrd0));

    ahb_subordinate_sram #(.DATA_WDT(32), .ADDR_WDT(16), .WAIT_STATES(3)) u_dut1 (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(sel == 1'b1), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hready_g), .o_hreadyout(hrdy1), .o_hresp(resp1),
        .o_hrdata(rdata1), .i_retry_req(retry1), .o_mem_en(men1), .o_mem_we(mwe1),
        .o_mem_addr(maddr1), .o_mem_be(mbe1), .o_mem_wdata(mwd1), .i_mem_rdata(mrd1));

    // Interconnect HREADY mux: data-phase owner is whoever was selected at the last ready edge.
    assign hready_g = owner ? hrdy1 : hrdy0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner <= 1'b0;
        else if (hready_g) owner <= sel;
    end

    logic [31:0] mem0 [0:16383];
    logic [31:0] mem1 [0:16383];
    always @(posedge clk) begin
        if (men0) begin
            if (mwe0) begin
                for (int b = 0; b < 4; b++) if (mbe0[b]) mem0[maddr0][b*8 +: 8] <= mwd0[b*8 +: 8];
            end else mrd0 <= mem0[maddr0];
        end
        if (men1) begin
            if (mwe1) begin
                for (int b = 0; b < 4; b++) if (mbe1[b]) mem1[maddr1][b*8 +: 8] <= mwd1[b*8 +: 8];
            end else mrd1 <= mem1[maddr1];
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] data;
        t_hresp      resp;
        int          cycles;
        int          strobes;
        logic [3:0]  be;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: follows each accepted data phase of its owner and checks it on completion.
    logic        dp_active = 1'b0;
    logic        dp_dut = 1'b0;
    int          dp_cyc, dp_str;
    logic [3:0]  dp_be;
    t_hresp      dp_rsp;
    t_hresp      m_rsp;
    logic        m_en, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_rd;
    assign m_rsp = dp_dut ? resp1 : resp0;
    assign m_en  = dp_dut ? men1 : men0;
    assign m_we  = dp_dut ? mwe1 : mwe0;
    assign m_be  = dp_dut ? mbe1 : mbe0;
    assign m_rd  = dp_dut ? rdata1 : rdata0;

    always @(negedge clk) begin
        if (!rst_n) begin
            dp_active = 1'b0;
            q.delete();
        end else begin
            if (dp_active) begin
                dp_cyc++;
                if (m_rsp != cur.resp) dp_rsp = m_rsp;
                if (m_en) begin
                    dp_str++;
                    if (m_we) dp_be = m_be;
                end
                if (hready_g) begin
                    chk({cur.nm, " resp"}, 32'(dp_rsp), 32'(cur.resp));
                    chk({cur.nm, " cycles"}, 32'(dp_cyc), 32'(cur.cycles));
                    chk({cur.nm, " mem strobes"}, 32'(dp_str), 32'(cur.strobes));
                    if (cur.resp == HRESP_OKAY) begin
                        if (cur.wr) chk({cur.nm, " mem_be"}, 32'(dp_be), 32'(cur.be));
                        else        chk({cur.nm, " hrdata"}, m_rd, cur.data);
                    end
                    dp_active = 1'b0;
                end
            end
            if (hready_g && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected transfer: addr 0x%08h with empty scoreboard", haddr);
                end else begin
                    cur       = q.pop_front();
                    dp_dut    = sel;
                    dp_active = 1'b1;
                    dp_cyc    = 0;
                    dp_str    = 0;
                    dp_be     = 4'h0;
                    dp_rsp    = cur.resp;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!hready_g && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!hready_g) begin
            n_chk++;
            n_err++;
            $display("FAIL hready timeout: got 0, expected 1 within 64 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_wd [4];
    logic [31:0] v_ed [4];

    // Issues n pipelined beats; write data for beat i is driven during its data phase.
    task automatic burst(input logic dut, input logic wr, input logic [31:0] base, input int n,
                         input t_hsize sz, input t_hburst hb, input t_hresp er, input int ecyc,
                         input int estr, input logic [3:0] ebe, input string nm);
        exp_t e;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                sel    = dut;
                htrans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr  = base + 32'(i * 4);
                hwrite = wr;
                hsize  = sz;
                hburst = hb;
                e.wr = wr; e.data = v_ed[i]; e.resp = er; e.cycles = ecyc;
                e.strobes = estr; e.be = ebe; e.nm = $sformatf("%s[%0d]", nm, i);
                q.push_back(e);
            end else begin
                htrans = HTRANS_IDLE;
            end
            if (i > 0) hwdata = v_wd[i-1];
            wait_ready();
        end
        htrans = HTRANS_IDLE;
    endtask

    task automatic single(input logic dut, input logic wr, input logic [31:0] addr, input t_hsize sz,
                          input logic [31:0] d, input t_hresp er, input int ecyc, input int estr,
                          input logic [3:0] ebe, input string nm);
        v_wd[0] = d;
        v_ed[0] = d;
        burst(dut, wr, addr, 1, sz, HBURST_SINGLE, er, ecyc, estr, ebe, nm);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; sel = 1'b0; haddr = '0; hwdata = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hburst = HBURST_SINGLE; retry0 = 1'b0; retry1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset hreadyout0", 32'(hrdy0), 32'd1);
        chk("reset hreadyout1", 32'(hrdy1), 32'd1);
        chk("reset hresp0", 32'(resp0), 32'(HRESP_OKAY));
        chk("reset hrdata0", rdata0, 32'h0);
        chk("reset mem_en0", 32'(men0), 32'd0);
        chk("reset mem_en1", 32'(men1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait subordinate: word, byte and halfword paths.
        single(1'b0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, HRESP_OKAY, 1, 1, 4'hF, "wr32");
        single(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'hDEADBEEF, HRESP_OKAY, 2, 1, 4'h0, "rd32");
        single(1'b0, 1'b1, 32'h13, HSIZE_BYTE, 32'hA5000000, HRESP_OKAY, 1, 1, 4'b1000, "wr8");
        chk("hrdata held after write", rdata0, 32'hDEADBEEF);
        single(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'hA5ADBEEF, HRESP_OKAY, 2, 1, 4'h0, "rd32 merged");
        single(1'b0, 1'b1, 32'h14, HSIZE_WORD, 32'hCAFEF00D, HRESP_OKAY, 1, 1, 4'hF, "wr32 b");
        single(1'b0, 1'b1, 32'h16, HSIZE_HWORD, 32'h12340000, HRESP_OKAY, 1, 1, 4'b1100, "wr16");
        single(1'b0, 1'b0, 32'h16, HSIZE_HWORD, 32'h1234F00D, HRESP_OKAY, 2, 1, 4'h0, "rd16");

        // Three-wait subordinate: pipelined INCR4 write then read.
        v_wd[0] = 32'h11111111; v_wd[1] = 32'h22222222; v_wd[2] = 32'h33333333; v_wd[3] = 32'h44444444;
        burst(1'b1, 1'b1, 32'h20, 4, HSIZE_WORD, HBURST_INCR4, HRESP_OKAY, 4, 1, 4'hF, "wr incr4");
        v_ed[0] = 32'h11111111; v_ed[1] = 32'h22222222; v_ed[2] = 32'h33333333; v_ed[3] = 32'h44444444;
        burst(1'b1, 1'b0, 32'h20, 4, HSIZE_WORD, HBURST_INCR4, HRESP_OKAY, 5, 1, 4'h0, "rd incr4");

        // Illegal accesses: out of range, oversize, misaligned.
        single(1'b0, 1'b0, 32'h00010000, HSIZE_WORD, 32'h0, HRESP_ERROR, 2, 0, 4'h0, "err range");
        single(1'b0, 1'b1, 32'h0, HSIZE_DWORD, 32'h0, HRESP_ERROR, 2, 0, 4'h0, "err size");
        single(1'b0, 1'b1, 32'h11, HSIZE_HWORD, 32'hFFFFFFFF, HRESP_ERROR, 2, 0, 4'h0, "err align");
        single(1'b1, 1'b0, 32'h00020000, HSIZE_WORD, 32'h0, HRESP_ERROR, 2, 0, 4'h0, "err range ws3");
        single(1'b0, 1'b0, 32'h10, HSIZE_WORD, 32'hA5ADBEEF, HRESP_OKAY, 2, 1, 4'h0, "rd after err");

        // Retry request, replay, and read-back.
        retry0 = 1'b1;
        @(posedge clk);
        #1;
        retry0 = 1'b0;
        single(1'b0, 1'b1, 32'h40, HSIZE_WORD, 32'h55AA55AA, HRESP_RETRY, 2, 0, 4'h0, "wr retried");
        single(1'b0, 1'b1, 32'h40, HSIZE_WORD, 32'h55AA55AA, HRESP_OKAY, 1, 1, 4'hF, "wr replay");
        single(1'b0, 1'b0, 32'h40, HSIZE_WORD, 32'h55AA55AA, HRESP_OKAY, 2, 1, 4'h0, "rd replay");

        // Reset while the three-wait subordinate is inside its WAIT state.
        sel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h50; hwrite = 1'b1; hsize = HSIZE_WORD;
        hburst = HBURST_SINGLE;
        e.wr = 1'b1; e.data = 32'h0; e.resp = HRESP_OKAY; e.cycles = 4; e.strobes = 1; e.be = 4'hF;
        e.nm = "aborted";
        q.push_back(e);
        wait_ready();
        htrans = HTRANS_IDLE;
        hwdata = 32'hFFFF0000;
        @(posedge clk);
        #3;
        chk("pre-reset hreadyout1", 32'(hrdy1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid reset hreadyout1", 32'(hrdy1), 32'd1);
        chk("mid reset hresp1", 32'(resp1), 32'(HRESP_OKAY));
        chk("mid reset mem_en1", 32'(men1), 32'd0);
        chk("mid reset mem_we1", 32'(mwe1), 32'd0);
        chk("mid reset hrdata1", rdata1, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        single(1'b1, 1'b1, 32'h50, HSIZE_WORD, 32'h0BADF00D, HRESP_OKAY, 4, 1, 4'hF, "wr after rst");
        single(1'b1, 1'b0, 32'h50, HSIZE_WORD, 32'h0BADF00D, HRESP_OKAY, 5, 1, 4'h0, "rd after rst");
        single(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h11111111, HRESP_OKAY, 5, 1, 4'h0, "rd old data");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
